// File: rtl/pll_rst_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and
// constant-function helpers used to size internal counters.
package pll_rst_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses PLL RESETB, waits for a stable lock, then
// releases the system reset and generates divided clock enables.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int unsigned           PLL_RST_CYCLES = 16,
  parameter int unsigned           LOCK_TIMEOUT   = 65536,
  parameter int unsigned           LOCK_STABLE    = 1024,
  parameter int unsigned           N_CE           = 2,
  parameter int unsigned           DIV_W          = 8,
  parameter logic [N_CE*DIV_W-1:0] CE_DIVS        = {8'd2, 8'd1}
) (
  input  logic            clock_in,
  input  logic            reset_n,
  input  logic            pll_lock,
  output logic            pll_resetb,
  output logic            rst_out_n,
  output logic [N_CE-1:0] ce,
  output logic [1:0]      state,
  output logic [7:0]      retries
);

  localparam int unsigned MAX_CYC = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int unsigned CNT_W   = (clog2(MAX_CYC) < 1) ? 1 : clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

  localparam logic [1:0] S_PLL_RST   = PLL_RST;
  localparam logic [1:0] S_WAIT_LOCK = WAIT_LOCK;
  localparam logic [1:0] S_STABLE    = STABLE;
  localparam logic [1:0] S_RUN       = RUN;

  logic             w_lock_s;
  logic [1:0]       r_state;
  logic [1:0]       w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [7:0]       r_retries;
  logic [7:0]       w_retries_d;
  logic             w_retry_evt;

  sync2 u_sync_lock (
    .i_clk  (clock_in),
    .i_rst_n(reset_n),
    .i_d    (pll_lock),
    .o_q    (w_lock_s)
  );

  // Next-state, cycle counter and retry-event decode.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt + 1'b1;
    w_retry_evt = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_d = S_WAIT_LOCK;
          w_cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_d = S_STABLE;
          w_cnt_d   = '0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_state_d   = S_PLL_RST;
          w_cnt_d     = '0;
          w_retry_evt = 1'b1;
        end
      end
      S_STABLE: begin
        // A lock drop here is treated as a glitch: back to waiting, no retry.
        if (!w_lock_s) begin
          w_state_d = S_WAIT_LOCK;
          w_cnt_d   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_d = S_RUN;
          w_cnt_d   = '0;
        end
      end
      default: begin
        w_cnt_d = '0;
        if (!w_lock_s) begin
          w_state_d   = S_PLL_RST;
          w_retry_evt = 1'b1;
        end
      end
    endcase
  end

  // Saturating retry counter next value.
  always_comb begin
    w_retries_d = r_retries;
    if (w_retry_evt && (r_retries != 8'hFF)) w_retries_d = r_retries + 8'd1;
  end

  // FSM, cycle counter and retry registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_PLL_RST;
      r_cnt     <= '0;
      r_retries <= 8'd0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_retries <= w_retries_d;
    end
  end

  for (genvar gi = 0; gi < N_CE; gi++) begin : g_ce
    localparam logic [DIV_W-1:0] DIV_RAW = CE_DIVS[gi*DIV_W +: DIV_W];
    // A zero divisor behaves as divide-by-one.
    localparam logic [DIV_W-1:0] DIV_LAST = (DIV_RAW == '0) ? '0 : DIV_RAW - 1'b1;

    logic [DIV_W-1:0] r_div_cnt;

    // Count RUN cycles modulo the divisor; held at zero outside RUN.
    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        r_div_cnt <= '0;
      end else if ((r_state == S_RUN) && (w_state_d == S_RUN)) begin
        r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
      end else begin
        r_div_cnt <= '0;
      end
    end

    assign ce[gi] = (r_state == S_RUN) && (r_div_cnt == DIV_LAST);
  end

  assign pll_resetb = (r_state != S_PLL_RST);
  assign rst_out_n  = (r_state == S_RUN);
  assign state      = r_state;
  assign retries    = r_retries;

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, meaning the number of cycles pll_resetb is held low per PLL reset.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536, meaning the number of cycles to wait for lock before the PLL is reset again.
REQ-003 SHALL have parameter LOCK_STABLE, default 1024, meaning the number of consecutive synchronised-lock cycles required before the system reset is released.
REQ-004 SHALL have parameter N_CE, default 2, meaning the number of clock-enable channels.
REQ-005 SHALL have parameter DIV_W, default 8, meaning the width of each channel divisor.
REQ-006 SHALL have parameter CE_DIVS, default {8'd2, 8'd1}, meaning the packed N_CE*DIV_W divisors, with channel i at bits [i*DIV_W +: DIV_W].
REQ-007 SHALL have port clock_in, input, 1 bit: the single clock (PLL output domain); one clock only.
REQ-008 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port pll_lock, input, 1 bit: PLL LOCK, asynchronous to clock_in.
REQ-010 SHALL have port pll_resetb, output, 1 bit: drives PLL RESETB, active-low.
REQ-011 SHALL have port rst_out_n, output, 1 bit: synchronous system reset, active-low.
REQ-012 SHALL have port ce, output, N_CE bits: per-channel clock enables.
REQ-013 SHALL have port state, output, 2 bits: current FSM state encoding.
REQ-014 SHALL have port retries, output, 8 bits: saturating count of lock timeouts plus lock losses.

Function
REQ-015 SHALL synchronise pll_lock through 2 flops to lock_s; all decisions SHALL use lock_s only.
REQ-016 SHALL implement the FSM states PLL_RST=0, WAIT_LOCK=1, STABLE=2 and RUN=3, all registered.
REQ-017 In PLL_RST, pll_resetb SHALL be 0; the cycle counter SHALL count to PLL_RST_CYCLES-1, and the FSM SHALL then go to WAIT_LOCK with the counter cleared.
REQ-018 In WAIT_LOCK, lock_s=1 SHALL go to STABLE with the counter cleared; otherwise, when the counter reaches LOCK_TIMEOUT-1, the FSM SHALL go to PLL_RST and increment retries.
REQ-019 In STABLE with lock_s=1: counter==LOCK_STABLE-1 SHALL go to RUN, else the counter SHALL increment.
REQ-020 In STABLE, lock_s=0 SHALL return to WAIT_LOCK with the counter cleared, and retries SHALL NOT change (glitch tolerance).
REQ-021 In RUN, lock_s=0 SHALL go to PLL_RST on the next edge and increment retries.
REQ-022 rst_out_n SHALL be 1 exactly while state==RUN, deasserting in the same cycle state leaves RUN.
REQ-023 pll_resetb SHALL be 1 in all states except PLL_RST.
REQ-024 Each channel divider counter SHALL be 0 in the first RUN cycle, increment each RUN cycle and wrap to 0 after D-1.
REQ-025 ce[i] SHALL be asserted when state==RUN and counter_i==D_i-1, i.e. one pulse every D_i cycles, first on the D_i-th RUN cycle.
REQ-026 D_i=1 SHALL give ce[i] constantly 1 in RUN; D_i=0 SHALL be treated as 1.
REQ-027 ce SHALL be all 0 outside RUN, and the counters SHALL be cleared on leaving RUN.
REQ-028 retries SHALL saturate at 255 and never wrap.
REQ-029 If a timeout or lock loss coincides with saturation, retries SHALL stay at 255.
REQ-030 The state counter SHALL be sized clog2 of the maximum of the three cycle parameters, with no overflow possible.

Reset
REQ-031 reset_n=0 SHALL asynchronously force state=PLL_RST, all counters 0, sync flops 0 and retries=0.
REQ-032 During reset, outputs SHALL be pll_resetb=0, rst_out_n=0 and ce=0.
REQ-033 Reset asserted mid-RUN SHALL drop rst_out_n and ce immediately (asynchronously).
REQ-034 After reset_n rises, the full PLL_RST sequence SHALL restart.

Structure
REQ-035 A shared package SHALL hold the state enum (PLL_RST, WAIT_LOCK, STABLE, RUN) and the clog2 helper.
REQ-036 There SHALL be one sub-module, sync2 (a 2-flop synchroniser with async active-low reset), reused for pll_lock.
REQ-037 The PLL primitive SHALL NOT be instantiated inside this block.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=64, LOCK_STABLE=16, CE_DIVS={3,1})
REQ-038 Release reset, then raise pll_lock at cycle 10 and hold it -> pll_resetb is low for 4 cycles, and rst_out_n rises on the 19th edge after pll_lock is first sampled high.
REQ-039 In RUN -> ce[0] is constantly 1; ce[1] pulses on RUN cycles 3, 6, 9, ..., each pulse 1 cycle wide.
REQ-040 Hold pll_lock=0 for 300 cycles -> repeated PLL_RST/WAIT_LOCK loops (4+64 cycles each) and retries increments once per timeout.
REQ-041 Pulse pll_lock low for 1 cycle at STABLE count 10 -> return to WAIT_LOCK, the count restarts, and retries is unchanged.
REQ-042 Drop pll_lock in RUN -> rst_out_n=0 and ce=0 within 3 edges, retries increments by 1, and the PLL_RST sequence restarts.
REQ-043 Force 300 timeouts, then assert reset_n=0 mid-RUN -> retries holds 255; on reset, outputs clear asynchronously and retries=0.
